ysyx_24090012_xbar: RTL and testbench
=====================================

# ysyx_24090012_xbar

Address-decoding 1-to-2 AXI4 router placed between the LSU/IFU arbiter's downstream port and the system: it steers each transaction to the read-only CLINT or to the external memory bus. It locally terminates illegal accesses with an error response. It handles one transaction at a time, priority-sequenced like the arbiter upstream, so neither slave is ever driven by more than one outstanding request.

## Interface
- CLINT_BASE, 32'h0200_0000, CLINT window base.
- CLINT_MASK, 32'hFFFF_0000, address bits compared for CLINT hit.
- HOLE_BASE, 32'h0000_0000, unmapped window base.
- HOLE_MASK, 32'hF000_0000, address bits compared for unmapped hit.
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- up_aw{valid in 1, ready out 1, addr in 32, id in 4, len in 8, size in 3, burst in 2}  write address from arbiter.
- up_w{valid in 1, ready out 1, data in 32, strb in 4, last in 1}  write data.
- up_b{valid out 1, ready in 1, resp out 2, id out 4}  write response.
- up_ar{valid in 1, ready out 1, addr in 32, id in 4, len in 8, size in 3, burst in 2}  read address.
- up_r{valid out 1, ready in 1, data out 32, resp out 2, last out 1, id out 4}  read data.
- mem_aw*/mem_w*/mem_b*/mem_ar*/mem_r*  same fields, opposite directions  full AXI4 master to external memory.
- clint_ar{valid,ready,addr,id,len,size,burst}, clint_r{valid,ready,data,resp,last,id}  read-only AXI4 master to CLINT.

## Operation
- Decode: CLINT hit = (addr & CLINT_MASK) == CLINT_BASE; HOLE hit = (addr & HOLE_MASK) == HOLE_BASE; CLINT checked first; otherwise MEM.
- States: IDLE, RD_MEM, RD_CLINT, RD_ERR, WR_MEM, WR_ERR.
- IDLE: all up readies 0, all down valids 0. If up_awvalid: decode awaddr → WR_MEM (MEM), else WR_ERR (CLINT writes → SLVERR 2'b10, HOLE → DECERR 2'b11). Else if up_arvalid: → RD_CLINT / RD_MEM / RD_ERR (DECERR). Write beats read when both valid.
- Decode result, error code, awid/arid, arlen latched on the IDLE→busy transition.
- RD_MEM/RD_CLINT: ar and r channels wired straight through to the selected slave; the other slave sees valid/ready 0. Exit to IDLE on r handshake with rlast=1.
- WR_MEM: aw, w, b wired through to mem. Exit on b handshake.
- RD_ERR: up_arready=1 until the ar handshake. Then it emits arlen+1 beats: rdata=0, rresp=11, rid=latched id, rlast=1 on the final beat only. An 8-bit beat counter advances on each r handshake. Exit after the last-beat handshake.
- WR_ERR: up_awready=1 until the aw handshake. up_wready=1 and beats are discarded until the w handshake with wlast=1. bvalid=1 then follows with the latched error code and id; exit on b handshake.
- The CLINT never sees writes; mem_* and clint_* are never active simultaneously.

## Timing
- Reset: state IDLE, beat counter 0, every *valid/*ready output 0, resp/id/data outputs 0.
- IDLE→busy costs 1 cycle. There is no combinational path from up_*valid to down *valid in IDLE.
- Busy states are pure wires: 0 added latency per beat. Down-valid follows up-valid in the same cycle, and so on.
- Return to IDLE occurs the cycle after the final handshake. The next transaction is accepted no earlier than the following IDLE cycle, giving a minimum of 1 bubble between transactions.
- Error responses: first up_rvalid/up_bvalid is asserted 1 cycle after the last address/data handshake. up_rvalid is held while up_rready=0, and data/resp stay stable.
- arlen=255 error read: counter reaches 255, last beat flagged, no wrap.
- An aw that arrives during a read is ignored until IDLE; the upstream holds it (AXI rule).
- rst mid-transaction: immediate return to IDLE with all outputs 0 on the next edge. Slaves are reset by the same rst.

## Test plan
- Read 0x8000_0000, len 0 → routed to mem_ar, mem_rdata 0x1234_5678 returned on up_rdata, resp 00; clint_arvalid stays 0.
- Read 0x0200_BFF8, len 0 → clint_araddr 0x0200_BFF8, CLINT data forwarded, state back to IDLE after rlast handshake.
- Read 0x0000_1000, len 3, up_rready toggling → exactly 4 beats rresp=11, rdata=0, rlast only on beat 4, no down valid asserted.
- Write 0x0200_0000, 2 beats → both w beats accepted locally, bresp=10; mem_awvalid and clint signals stay 0.
- up_awvalid and up_arvalid both asserted in IDLE for mem addresses → write completes fully (b handshake) before mem_arvalid is first raised.
- rst asserted while in RD_MEM mid-burst → next cycle all valids/readies 0, state IDLE, and a fresh read completes normally.

Source files
------------

// File: rtl/ysyx_24090012_xbar.sv
// Purpose: 1-to-2 AXI4 address router (CLINT read-only / external memory) with local error termination.
// Latency: 1 cycle IDLE->busy decode; busy states are pure wires (0 added cycles per beat).
// Backpressure: one transaction at a time; up readies follow the selected slave or the local error responder.
module ysyx_24090012_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000,
  parameter logic [31:0] HOLE_BASE  = 32'h0000_0000,
  parameter logic [31:0] HOLE_MASK  = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // upstream (from arbiter)
  input  logic        up_awvalid,
  output logic        up_awready,
  input  logic [31:0] up_awaddr,
  input  logic [3:0]  up_awid,
  input  logic [7:0]  up_awlen,
  input  logic [2:0]  up_awsize,
  input  logic [1:0]  up_awburst,
  input  logic        up_wvalid,
  output logic        up_wready,
  input  logic [31:0] up_wdata,
  input  logic [3:0]  up_wstrb,
  input  logic        up_wlast,
  output logic        up_bvalid,
  input  logic        up_bready,
  output logic [1:0]  up_bresp,
  output logic [3:0]  up_bid,
  input  logic        up_arvalid,
  output logic        up_arready,
  input  logic [31:0] up_araddr,
  input  logic [3:0]  up_arid,
  input  logic [7:0]  up_arlen,
  input  logic [2:0]  up_arsize,
  input  logic [1:0]  up_arburst,
  output logic        up_rvalid,
  input  logic        up_rready,
  output logic [31:0] up_rdata,
  output logic [1:0]  up_rresp,
  output logic        up_rlast,
  output logic [3:0]  up_rid,
  // external memory master
  output logic        mem_awvalid,
  input  logic        mem_awready,
  output logic [31:0] mem_awaddr,
  output logic [3:0]  mem_awid,
  output logic [7:0]  mem_awlen,
  output logic [2:0]  mem_awsize,
  output logic [1:0]  mem_awburst,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_wlast,
  input  logic        mem_bvalid,
  output logic        mem_bready,
  input  logic [1:0]  mem_bresp,
  input  logic [3:0]  mem_bid,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [31:0] mem_araddr,
  output logic [3:0]  mem_arid,
  output logic [7:0]  mem_arlen,
  output logic [2:0]  mem_arsize,
  output logic [1:0]  mem_arburst,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  input  logic        mem_rlast,
  input  logic [3:0]  mem_rid,
  // CLINT master (read-only)
  output logic        clint_arvalid,
  input  logic        clint_arready,
  output logic [31:0] clint_araddr,
  output logic [3:0]  clint_arid,
  output logic [7:0]  clint_arlen,
  output logic [2:0]  clint_arsize,
  output logic [1:0]  clint_arburst,
  input  logic        clint_rvalid,
  output logic        clint_rready,
  input  logic [31:0] clint_rdata,
  input  logic [1:0]  clint_rresp,
  input  logic        clint_rlast,
  input  logic [3:0]  clint_rid
);

  typedef enum logic [2:0] {IDLE, RD_MEM, RD_CLINT, RD_ERR, WR_MEM, WR_ERR} state_t;

  state_t     state, state_nxt;
  logic [1:0] err_code;   // bresp for locally terminated writes
  logic [3:0] txn_id;
  logic [7:0] txn_len;
  logic [7:0] beat_cnt;
  logic       addr_done;  // error responder has consumed the address beat
  logic       data_done;  // error responder has consumed the wlast beat

  logic aw_clint, aw_hole, ar_clint, ar_hole;
  assign aw_clint = (up_awaddr & CLINT_MASK) == CLINT_BASE;
  assign aw_hole  = (up_awaddr & HOLE_MASK) == HOLE_BASE;
  assign ar_clint = (up_araddr & CLINT_MASK) == CLINT_BASE;
  assign ar_hole  = (up_araddr & HOLE_MASK) == HOLE_BASE;

  logic err_rlast;
  assign err_rlast = (beat_cnt == txn_len);

  // State register plus transaction context latched on leaving IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      err_code  <= 2'b00;
      txn_id    <= 4'd0;
      txn_len   <= 8'd0;
      beat_cnt  <= 8'd0;
      addr_done <= 1'b0;
      data_done <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          beat_cnt  <= 8'd0;
          addr_done <= 1'b0;
          data_done <= 1'b0;
          if (up_awvalid) begin
            txn_id   <= up_awid;
            err_code <= aw_clint ? 2'b10 : 2'b11;
          end else if (up_arvalid) begin
            txn_id   <= up_arid;
            txn_len  <= up_arlen;
            err_code <= 2'b11;
          end
        end
        RD_ERR: begin
          if (up_arvalid && !addr_done) addr_done <= 1'b1;
          // hold at the final count instead of wrapping (arlen = 255)
          if (addr_done && up_rready && !err_rlast) beat_cnt <= beat_cnt + 8'd1;
        end
        WR_ERR: begin
          if (up_awvalid && !addr_done) addr_done <= 1'b1;
          if (up_wvalid && up_wlast && !data_done) data_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and channel steering; everything idles at 0
  always_comb begin
    state_nxt     = state;
    up_awready    = 1'b0;
    up_wready     = 1'b0;
    up_bvalid     = 1'b0;
    up_bresp      = 2'b00;
    up_bid        = 4'd0;
    up_arready    = 1'b0;
    up_rvalid     = 1'b0;
    up_rdata      = 32'd0;
    up_rresp      = 2'b00;
    up_rlast      = 1'b0;
    up_rid        = 4'd0;
    mem_awvalid   = 1'b0;
    mem_awaddr    = 32'd0;
    mem_awid      = 4'd0;
    mem_awlen     = 8'd0;
    mem_awsize    = 3'd0;
    mem_awburst   = 2'd0;
    mem_wvalid    = 1'b0;
    mem_wdata     = 32'd0;
    mem_wstrb     = 4'd0;
    mem_wlast     = 1'b0;
    mem_bready    = 1'b0;
    mem_arvalid   = 1'b0;
    mem_araddr    = 32'd0;
    mem_arid      = 4'd0;
    mem_arlen     = 8'd0;
    mem_arsize    = 3'd0;
    mem_arburst   = 2'd0;
    mem_rready    = 1'b0;
    clint_arvalid = 1'b0;
    clint_araddr  = 32'd0;
    clint_arid    = 4'd0;
    clint_arlen   = 8'd0;
    clint_arsize  = 3'd0;
    clint_arburst = 2'd0;
    clint_rready  = 1'b0;
    case (state)
      IDLE: begin
        // writes win over reads; nothing is driven downstream this cycle
        if (up_awvalid)      state_nxt = (aw_clint || aw_hole) ? WR_ERR : WR_MEM;
        else if (up_arvalid) state_nxt = ar_clint ? RD_CLINT : (ar_hole ? RD_ERR : RD_MEM);
      end
      RD_MEM: begin
        mem_arvalid = up_arvalid;
        mem_araddr  = up_araddr;
        mem_arid    = up_arid;
        mem_arlen   = up_arlen;
        mem_arsize  = up_arsize;
        mem_arburst = up_arburst;
        up_arready  = mem_arready;
        up_rvalid   = mem_rvalid;
        up_rdata    = mem_rdata;
        up_rresp    = mem_rresp;
        up_rlast    = mem_rlast;
        up_rid      = mem_rid;
        mem_rready  = up_rready;
        if (mem_rvalid && up_rready && mem_rlast) state_nxt = IDLE;
      end
      RD_CLINT: begin
        clint_arvalid = up_arvalid;
        clint_araddr  = up_araddr;
        clint_arid    = up_arid;
        clint_arlen   = up_arlen;
        clint_arsize  = up_arsize;
        clint_arburst = up_arburst;
        up_arready    = clint_arready;
        up_rvalid     = clint_rvalid;
        up_rdata      = clint_rdata;
        up_rresp      = clint_rresp;
        up_rlast      = clint_rlast;
        up_rid        = clint_rid;
        clint_rready  = up_rready;
        if (clint_rvalid && up_rready && clint_rlast) state_nxt = IDLE;
      end
      RD_ERR: begin
        up_arready = !addr_done;
        up_rvalid  = addr_done;
        up_rresp   = addr_done ? 2'b11 : 2'b00;
        up_rid     = addr_done ? txn_id : 4'd0;
        up_rlast   = addr_done && err_rlast;
        if (addr_done && up_rready && err_rlast) state_nxt = IDLE;
      end
      WR_MEM: begin
        mem_awvalid = up_awvalid;
        mem_awaddr  = up_awaddr;
        mem_awid    = up_awid;
        mem_awlen   = up_awlen;
        mem_awsize  = up_awsize;
        mem_awburst = up_awburst;
        up_awready  = mem_awready;
        mem_wvalid  = up_wvalid;
        mem_wdata   = up_wdata;
        mem_wstrb   = up_wstrb;
        mem_wlast   = up_wlast;
        up_wready   = mem_wready;
        up_bvalid   = mem_bvalid;
        up_bresp    = mem_bresp;
        up_bid      = mem_bid;
        mem_bready  = up_bready;
        if (mem_bvalid && up_bready) state_nxt = IDLE;
      end
      WR_ERR: begin
        up_awready = !addr_done;
        up_wready  = !data_done;
        up_bvalid  = addr_done && data_done;
        up_bresp   = up_bvalid ? err_code : 2'b00;
        up_bid     = up_bvalid ? txn_id : 4'd0;
        if (up_bvalid && up_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24090012_xbar.sv
// Purpose: self-checking bench for the 1-to-2 AXI4 router with directed read/write vectors.
// Latency: checks 1-cycle decode, pass-through beats and error-responder timing.
// Backpressure: exercises slave ready stalls and up_rready toggling on error bursts.
module tb_ysyx_24090012_xbar;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        up_awvalid, up_awready; logic [31:0] up_awaddr; logic [3:0] up_awid;
  logic [7:0]  up_awlen; logic [2:0] up_awsize; logic [1:0] up_awburst;
  logic        up_wvalid, up_wready; logic [31:0] up_wdata; logic [3:0] up_wstrb; logic up_wlast;
  logic        up_bvalid, up_bready; logic [1:0] up_bresp; logic [3:0] up_bid;
  logic        up_arvalid, up_arready; logic [31:0] up_araddr; logic [3:0] up_arid;
  logic [7:0]  up_arlen; logic [2:0] up_arsize; logic [1:0] up_arburst;
  logic        up_rvalid, up_rready; logic [31:0] up_rdata; logic [1:0] up_rresp;
  logic        up_rlast; logic [3:0] up_rid;
  logic        mem_awvalid, mem_awready; logic [31:0] mem_awaddr; logic [3:0] mem_awid;
  logic [7:0]  mem_awlen; logic [2:0] mem_awsize; logic [1:0] mem_awburst;
  logic        mem_wvalid, mem_wready; logic [31:0] mem_wdata; logic [3:0] mem_wstrb; logic mem_wlast;
  logic        mem_bvalid, mem_bready; logic [1:0] mem_bresp; logic [3:0] mem_bid;
  logic        mem_arvalid, mem_arready; logic [31:0] mem_araddr; logic [3:0] mem_arid;
  logic [7:0]  mem_arlen; logic [2:0] mem_arsize; logic [1:0] mem_arburst;
  logic        mem_rvalid, mem_rready; logic [31:0] mem_rdata; logic [1:0] mem_rresp;
  logic        mem_rlast; logic [3:0] mem_rid;
  logic        clint_arvalid, clint_arready; logic [31:0] clint_araddr; logic [3:0] clint_arid;
  logic [7:0]  clint_arlen; logic [2:0] clint_arsize; logic [1:0] clint_arburst;
  logic        clint_rvalid, clint_rready; logic [31:0] clint_rdata; logic [1:0] clint_rresp;
  logic        clint_rlast; logic [3:0] clint_rid;

  ysyx_24090012_xbar dut (
    .clk(clk), .rst(rst),
    .up_awvalid(up_awvalid), .up_awready(up_awready), .up_awaddr(up_awaddr), .up_awid(up_awid),
    .up_awlen(up_awlen), .up_awsize(up_awsize), .up_awburst(up_awburst),
    .up_wvalid(up_wvalid), .up_wready(up_wready), .up_wdata(up_wdata), .up_wstrb(up_wstrb),
    .up_wlast(up_wlast),
    .up_bvalid(up_bvalid), .up_bready(up_bready), .up_bresp(up_bresp), .up_bid(up_bid),
    .up_arvalid(up_arvalid), .up_arready(up_arready), .up_araddr(up_araddr), .up_arid(up_arid),
    .up_arlen(up_arlen), .up_arsize(up_arsize), .up_arburst(up_arburst),
    .up_rvalid(up_rvalid), .up_rready(up_rready), .up_rdata(up_rdata), .up_rresp(up_rresp),
    .up_rlast(up_rlast), .up_rid(up_rid),
    .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
    .mem_awid(mem_awid), .mem_awlen(mem_awlen), .mem_awsize(mem_awsize), .mem_awburst(mem_awburst),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_wlast(mem_wlast),
    .mem_bvalid(mem_bvalid), .mem_bready(mem_bready), .mem_bresp(mem_bresp), .mem_bid(mem_bid),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_arid(mem_arid), .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
    .mem_rlast(mem_rlast), .mem_rid(mem_rid),
    .clint_arvalid(clint_arvalid), .clint_arready(clint_arready), .clint_araddr(clint_araddr),
    .clint_arid(clint_arid), .clint_arlen(clint_arlen), .clint_arsize(clint_arsize),
    .clint_arburst(clint_arburst),
    .clint_rvalid(clint_rvalid), .clint_rready(clint_rready), .clint_rdata(clint_rdata),
    .clint_rresp(clint_rresp), .clint_rlast(clint_rlast), .clint_rid(clint_rid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    up_awvalid = 0; up_awaddr = 0; up_awid = 0; up_awlen = 0; up_awsize = 0; up_awburst = 0;
    up_wvalid = 0; up_wdata = 0; up_wstrb = 0; up_wlast = 0; up_bready = 0;
    up_arvalid = 0; up_araddr = 0; up_arid = 0; up_arlen = 0; up_arsize = 0; up_arburst = 0;
    up_rready = 0;
    mem_awready = 0; mem_wready = 0; mem_bvalid = 0; mem_bresp = 0; mem_bid = 0;
    mem_arready = 0; mem_rvalid = 0; mem_rdata = 0; mem_rresp = 0; mem_rlast = 0; mem_rid = 0;
    clint_arready = 0; clint_rvalid = 0; clint_rdata = 0; clint_rresp = 0; clint_rlast = 0;
    clint_rid = 0;
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_vld_rdy"}, {20'd0, up_awready, up_wready, up_bvalid, up_arready, up_rvalid,
          mem_awvalid, mem_wvalid, mem_bready, mem_arvalid, mem_rready, clint_arvalid,
          clint_rready}, 32'd0);
    check({tag, "_rdata"}, up_rdata, 32'd0);
    check({tag, "_resp_id"}, {19'd0, up_rlast, up_rresp, up_rid, up_bresp, up_bid}, 32'd0);
  endtask

  // tgt: 0 = mem, 1 = clint, 2 = local error
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                         input int tgt);
    logic [31:0] exp_data;
    @(negedge clk);
    clear_inputs();
    up_arvalid = 1; up_araddr = addr; up_arlen = len; up_arid = id; up_arsize = 3'd2;
    up_arburst = 2'd1;
    #1 idle_check("rd_idle");
    @(negedge clk);
    #1;
    check("rd_mem_arvalid", {31'd0, mem_arvalid}, {31'd0, tgt == 0});
    check("rd_clint_arvalid", {31'd0, clint_arvalid}, {31'd0, tgt == 1});
    if (tgt == 2) begin
      check("rd_err_arready", {31'd0, up_arready}, 32'd1);
      check("rd_err_rvalid_early", {31'd0, up_rvalid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      up_arvalid = 0;
      for (int b = 0; b <= int'(len); b++) begin
        up_rready = 0;
        #1;
        check("rd_err_rvalid", {31'd0, up_rvalid}, 32'd1);
        check("rd_err_rdata", up_rdata, 32'd0);
        check("rd_err_rresp", {30'd0, up_rresp}, 32'd3);
        check("rd_err_rlast", {31'd0, up_rlast}, {31'd0, b == int'(len)});
        check("rd_err_rid", {28'd0, up_rid}, {28'd0, id});
        @(negedge clk);
        up_rready = 1;
        #1;
        check("rd_err_hold_vld", {31'd0, up_rvalid}, 32'd1);
        check("rd_err_hold_last", {31'd0, up_rlast}, {31'd0, b == int'(len)});
        check("rd_err_no_down", {30'd0, mem_arvalid, clint_arvalid}, 32'd0);
        @(posedge clk);
        if (b != int'(len)) @(negedge clk);
      end
    end else begin
      check("rd_araddr", (tgt == 0) ? mem_araddr : clint_araddr, addr);
      check("rd_arlen", {24'd0, (tgt == 0) ? mem_arlen : clint_arlen}, {24'd0, len});
      check("rd_arready_stall", {31'd0, up_arready}, 32'd0);
      if (tgt == 0) mem_arready = 1; else clint_arready = 1;
      #1 check("rd_arready", {31'd0, up_arready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      up_arvalid = 0; mem_arready = 0; clint_arready = 0;
      for (int b = 0; b <= int'(len); b++) begin
        exp_data = ((tgt == 0) ? 32'h1234_5678 : 32'hCAFE_0000) + b;
        up_rready = 1;
        if (tgt == 0) begin
          mem_rvalid = 1; mem_rdata = exp_data; mem_rlast = (b == int'(len)); mem_rid = id;
        end else begin
          clint_rvalid = 1; clint_rdata = exp_data; clint_rlast = (b == int'(len));
          clint_rid = id;
        end
        #1;
        check("rd_rvalid", {31'd0, up_rvalid}, 32'd1);
        check("rd_rdata", up_rdata, exp_data);
        check("rd_rresp", {30'd0, up_rresp}, 32'd0);
        check("rd_rlast", {31'd0, up_rlast}, {31'd0, b == int'(len)});
        check("rd_rid", {28'd0, up_rid}, {28'd0, id});
        check("rd_rready_sel", {30'd0, mem_rready, clint_rready}, (tgt == 0) ? 32'd2 : 32'd1);
        @(posedge clk);
        if (b != int'(len)) @(negedge clk);
      end
    end
  endtask

  // tgt: 0 = mem, 2 = local error; resp is the slave's bresp for mem or the expected local code
  task automatic do_write(input logic [31:0] addr, input int nbeats, input logic [3:0] id,
                          input int tgt, input logic [1:0] resp, input bit keep_ar);
    @(negedge clk);
    clear_inputs();
    if (keep_ar) begin
      up_arvalid = 1; up_araddr = 32'h8000_0100; up_arid = 4'd6; up_arlen = 8'd0;
    end
    up_awvalid = 1; up_awaddr = addr; up_awid = id; up_awlen = 8'(nbeats - 1);
    up_awsize = 3'd2; up_awburst = 2'd1;
    #1 idle_check("wr_idle");
    @(negedge clk);
    #1;
    check("wr_clint_quiet", {31'd0, clint_arvalid}, 32'd0);
    check("wr_mem_ar_quiet", {31'd0, mem_arvalid}, 32'd0);
    check("wr_mem_awvalid", {31'd0, mem_awvalid}, {31'd0, tgt == 0});
    if (tgt == 0) begin
      check("wr_awaddr", mem_awaddr, addr);
      check("wr_awlen", {24'd0, mem_awlen}, nbeats - 1);
      check("wr_awready_stall", {31'd0, up_awready}, 32'd0);
      mem_awready = 1;
      #1 check("wr_awready", {31'd0, up_awready}, 32'd1);
    end else begin
      check("wr_err_awready", {31'd0, up_awready}, 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    up_awvalid = 0; mem_awready = 0;
    for (int b = 0; b < nbeats; b++) begin
      up_wvalid = 1; up_wdata = 32'hA000_0000 + b; up_wstrb = 4'hF; up_wlast = (b == nbeats - 1);
      if (tgt == 0) mem_wready = 1;
      #1;
      check("wr_wready", {31'd0, up_wready}, 32'd1);
      check("wr_mem_wvalid", {31'd0, mem_wvalid}, {31'd0, tgt == 0});
      check("wr_bvalid_early", {31'd0, up_bvalid}, 32'd0);
      check("wr_mem_ar_quiet2", {31'd0, mem_arvalid}, 32'd0);
      if (tgt == 0) check("wr_wdata", mem_wdata, 32'hA000_0000 + b);
      @(posedge clk);
      @(negedge clk);
    end
    up_wvalid = 0; up_wlast = 0; mem_wready = 0;
    if (tgt == 0) begin
      mem_bvalid = 1; mem_bresp = resp; mem_bid = id;
    end
    #1;
    check("wr_bvalid", {31'd0, up_bvalid}, 32'd1);
    check("wr_bresp", {30'd0, up_bresp}, {30'd0, resp});
    check("wr_bid", {28'd0, up_bid}, {28'd0, id});
    up_bready = 1;
    #1 check("wr_mem_bready", {31'd0, mem_bready}, {31'd0, tgt == 0});
    @(posedge clk);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    int          tgt;
  } rd_vec_t;

  rd_vec_t vecs[9];

  initial begin
    vecs[0] = '{32'h8000_0000, 8'd0,   4'd1, 0};
    vecs[1] = '{32'h0200_BFF8, 8'd0,   4'd2, 1};
    vecs[2] = '{32'h0000_1000, 8'd3,   4'd3, 2};
    vecs[3] = '{32'h0200_FFFC, 8'd1,   4'd4, 1};
    vecs[4] = '{32'h0201_0000, 8'd0,   4'd5, 2};
    vecs[5] = '{32'h1000_0000, 8'd2,   4'd6, 0};
    vecs[6] = '{32'h0FFF_FFFC, 8'd0,   4'd7, 2};
    vecs[7] = '{32'hFFFF_FFF0, 8'd1,   4'd8, 0};
    vecs[8] = '{32'h0000_0000, 8'd255, 4'd9, 2};

    clear_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 idle_check("reset");
    rst = 0;

    for (int i = 0; i < 9; i++)
      do_read(vecs[i].addr, vecs[i].len, vecs[i].id, vecs[i].tgt);

    do_write(32'h0200_0000, 2, 4'd3, 2, 2'b10, 1'b0);
    do_write(32'h0000_2000, 1, 4'd4, 2, 2'b11, 1'b0);
    do_write(32'h8000_0010, 3, 4'd5, 0, 2'b01, 1'b0);

    // simultaneous aw/ar: write must finish before mem_arvalid ever rises
    do_write(32'h8000_0040, 2, 4'd5, 0, 2'b00, 1'b1);
    do_read(32'h8000_0100, 8'd0, 4'd6, 0);

    // reset in the middle of a mem burst
    @(negedge clk);
    clear_inputs();
    up_arvalid = 1; up_araddr = 32'h8000_0200; up_arlen = 8'd3; up_arid = 4'd7;
    @(negedge clk);
    mem_arready = 1;
    @(posedge clk);
    @(negedge clk);
    up_arvalid = 0; mem_arready = 0;
    mem_rvalid = 1; mem_rdata = 32'h5555_AAAA; mem_rid = 4'd7; up_rready = 1;
    #1 check("rst_mid_rvalid", {31'd0, up_rvalid}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    #1 idle_check("rst_mid");
    rst = 0;
    do_read(32'h8000_0300, 8'd1, 4'd2, 0);

    @(negedge clk);
    clear_inputs();
    #1 idle_check("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
